// File: rtl/sram_like_slave_pkg.sv
// Shared types and constants for the sram-like memory-side responder.
package sram_like_pkg;

  localparam int unsigned DATA_W = 32;

  // Age counter width; bounds the largest usable LATENCY to 2**AGE_W - 1.
  localparam int unsigned AGE_W = 8;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned PTR_W = $clog2(DEPTH_DEFAULT);

  // Response data returned for writes.
  localparam logic [DATA_W-1:0] RESP_RDATA_WR = 32'h0;

  // One outstanding request in the response queue.
  typedef struct packed {
    logic              is_wr;
    logic [AGE_W-1:0]  age;
    logic              data_vld;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Pointer width for a queue of the given depth (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_like_slave_if.sv
// CPU-side sram-like request/response bus.
interface sram_like_slave_if;
  import sram_like_pkg::*;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_like_slave_resp_fifo.sv
// In-order queue of outstanding requests with per-entry age and data write-back.
// Slots are popped (rptr advanced) when their response is launched, but the
// occupancy count drops only when the caller releases them one cycle later.
module resp_fifo
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2,
  localparam int unsigned PB     = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              push_is_wr,
  input  logic              pop,
  input  logic              release_slot,
  input  logic              wb_en,
  input  logic [PB-1:0]     wb_ptr,
  input  logic [DATA_W-1:0] wb_data,
  output entry_t            head,
  output logic              head_valid,
  output logic [PB-1:0]     rptr,
  output logic [PB-1:0]     wptr,
  output logic [PB:0]       count
);

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic   [DEPTH-1:0] vld_q, vld_d;
  logic   [PB-1:0]    wptr_q, wptr_d;
  logic   [PB-1:0]    rptr_q, rptr_d;
  logic   [PB:0]      count_q, count_d;

  // Next-state: ageing, data write-back, pop, push, pointer/count update.
  always_comb begin
    ent_d   = ent_q;
    vld_d   = vld_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (32'(ent_q[i].age) < LATENCY)) begin
        ent_d[i].age = ent_q[i].age + 1'b1;
      end
    end

    if (wb_en) begin
      ent_d[wb_ptr].data     = wb_data;
      ent_d[wb_ptr].data_vld = 1'b1;
    end

    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end

    if (push) begin
      ent_d[wptr_q].is_wr    = push_is_wr;
      ent_d[wptr_q].age      = '0;
      ent_d[wptr_q].data_vld = 1'b0;
      ent_d[wptr_q].data     = '0;
      vld_d[wptr_q]          = 1'b1;
      wptr_d                 = wptr_q + 1'b1;
    end

    count_d = count_q + (PB+1)'(push) - (PB+1)'(release_slot);
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent_q   <= '0;
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      vld_q   <= vld_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head       = ent_q[rptr_q];
  assign head_valid = vld_q[rptr_q];
  assign rptr       = rptr_q;
  assign wptr       = wptr_q;
  assign count      = count_q;

endmodule

// File: rtl/sram_like_slave.sv
// Memory-side responder for an sram-like CPU port in front of a single-port
// synchronous RAM. Issues each accepted request to the RAM immediately and
// returns responses in acceptance order, no earlier than LATENCY cycles later.
module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_slave_if.slave    bus,
  output logic                ram_en,
  output logic [3:0]          ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int unsigned PB = ptr_width(DEPTH);

  entry_t            head;
  logic              head_valid;
  logic [PB-1:0]     rptr, wptr;
  logic [PB:0]       count;

  logic              acc;
  logic              bypass;
  logic              head_ready;
  logic              age_done;
  logic              fire;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] head_data;

  logic              wb_pend_q, wb_pend_d;
  logic [PB-1:0]     wb_ptr_q, wb_ptr_d;
  logic              wb_is_wr_q, wb_is_wr_d;
  logic              data_ok_q, data_ok_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              unused_bits;

  assign bus.addr_ok = (count < (PB+1)'(DEPTH));
  assign acc         = bus.req & bus.addr_ok;

  // RAM is driven straight from the accepted request.
  always_comb begin
    ram_en    = acc;
    ram_addr  = bus.addr[ADDR_W+1:2];
    ram_wdata = bus.wdata;
    ram_we    = (acc && bus.wr) ? bus.wstrb : 4'b0000;
  end

  // Track the slot awaiting RAM data one cycle after acceptance.
  always_comb begin
    wb_pend_d  = acc;
    wb_ptr_d   = wptr;
    wb_is_wr_d = bus.wr;
  end

  // Response launch: the head's data may still be on ram_rdata this cycle,
  // so it is bypassed around the queue. Launch happens a cycle before data_ok
  // is visible, with age counted from the cycle after acceptance, hence +2.
  always_comb begin
    wb_data    = wb_is_wr_q ? RESP_RDATA_WR : ram_rdata;
    bypass     = wb_pend_q && (wb_ptr_q == rptr);
    head_data  = bypass ? wb_data : head.data;
    head_ready = head.data_vld | bypass;
    age_done   = (32'(head.age) + 32'd2) >= LATENCY;
    fire       = head_valid & head_ready & age_done;
    data_ok_d  = fire;
    rdata_d    = fire ? head_data : rdata_q;
  end

  // Write-back tracking and registered response outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_pend_q  <= 1'b0;
      wb_ptr_q   <= '0;
      wb_is_wr_q <= 1'b0;
      data_ok_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wb_pend_q  <= wb_pend_d;
      wb_ptr_q   <= wb_ptr_d;
      wb_is_wr_q <= wb_is_wr_d;
      data_ok_q  <= data_ok_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;

  // The slot stays counted while its data_ok is on the bus.
  resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push         (acc),
    .push_is_wr   (bus.wr),
    .pop          (fire),
    .release_slot (data_ok_q),
    .wb_en        (wb_pend_q),
    .wb_ptr       (wb_ptr_q),
    .wb_data      (wb_data),
    .head         (head),
    .head_valid   (head_valid),
    .rptr         (rptr),
    .wptr         (wptr),
    .count        (count)
  );

  assign unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[31:ADDR_W+2], head.is_wr};

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench: a LATENCY=2 instance and a LATENCY=8 instance, each with a
// behavioural synchronous RAM, checked with immediate assertions.
module tb_sram_like_slave;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int unsigned passes = 0;
  int unsigned total  = 0;

  // Fast instance (LATENCY=2)
  sram_like_slave_if f_if();
  logic        f_ram_en;
  logic [3:0]  f_ram_we;
  logic [15:0] f_ram_addr;
  logic [31:0] f_ram_wdata;
  logic [31:0] f_ram_rdata = '0;
  logic [31:0] f_mem [0:255];

  sram_like_slave #(.DEPTH(4), .LATENCY(2), .ADDR_W(16)) u_fast (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (f_if),
    .ram_en    (f_ram_en),
    .ram_we    (f_ram_we),
    .ram_addr  (f_ram_addr),
    .ram_wdata (f_ram_wdata),
    .ram_rdata (f_ram_rdata)
  );

  always @(posedge clk) begin
    if (f_ram_en) begin
      f_ram_rdata <= f_mem[f_ram_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (f_ram_we[b]) f_mem[f_ram_addr[7:0]][b*8 +: 8] = f_ram_wdata[b*8 +: 8];
    end
  end

  // Slow instance (LATENCY=8)
  sram_like_slave_if s_if();
  logic        s_ram_en;
  logic [3:0]  s_ram_we;
  logic [15:0] s_ram_addr;
  logic [31:0] s_ram_wdata;
  logic [31:0] s_ram_rdata = '0;
  logic [31:0] s_mem [0:255];

  sram_like_slave #(.DEPTH(4), .LATENCY(8), .ADDR_W(16)) u_slow (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (s_if),
    .ram_en    (s_ram_en),
    .ram_we    (s_ram_we),
    .ram_addr  (s_ram_addr),
    .ram_wdata (s_ram_wdata),
    .ram_rdata (s_ram_rdata)
  );

  always @(posedge clk) begin
    if (s_ram_en) begin
      s_ram_rdata <= s_mem[s_ram_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (s_ram_we[b]) s_mem[s_ram_addr[7:0]][b*8 +: 8] = s_ram_wdata[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_stream [0:15];
  int          n;
  int          r;
  logic        exp_aok;
  logic        exp_dok;

  initial begin
    for (int i = 0; i < 256; i++) begin
      f_mem[i] = '0;
      s_mem[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      exp_stream[i] = 32'hA500_0000 | (i * 32'h0001_0101);
      f_mem[i]      = exp_stream[i];
    end
    f_mem[16] = 32'hDEAD_BEEF;
    f_mem[32] = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) s_mem[64 + i] = 32'hC0DE_0000 + i;

    {f_if.req, f_if.wr, f_if.size, f_if.wstrb, f_if.addr, f_if.wdata} = '0;
    {s_if.req, s_if.wr, s_if.size, s_if.wstrb, s_if.addr, s_if.wdata} = '0;

    // Reset release
    repeat (3) tick();
    resetn = 1'b1;
    #1;
    check("rst_addr_ok", 32'(f_if.addr_ok), 32'd1);
    check("rst_data_ok", 32'(f_if.data_ok), 32'd0);
    check("rst_rdata",   f_if.rdata,        32'h0);
    check("rst_ram_en",  32'(f_ram_en),     32'd0);
    check("rst_s_addr_ok", 32'(s_if.addr_ok), 32'd1);
    tick();

    // Single read of word 0x10
    f_if.req = 1'b1; f_if.wr = 1'b0; f_if.addr = 32'h40; f_if.size = 2'd2;
    #1;
    check("rd_addr_ok",  32'(f_if.addr_ok), 32'd1);
    check("rd_ram_en",   32'(f_ram_en),     32'd1);
    check("rd_ram_addr", 32'(f_ram_addr),   32'h10);
    check("rd_ram_we",   32'(f_ram_we),     32'h0);
    check("rd_dok_T0",   32'(f_if.data_ok), 32'd0);
    tick();
    f_if.req = 1'b0;
    #1;
    check("rd_dok_T1",   32'(f_if.data_ok), 32'd0);
    tick();
    check("rd_dok_T2",   32'(f_if.data_ok), 32'd1);
    check("rd_rdata_T2", f_if.rdata,        32'hDEAD_BEEF);
    tick();
    check("rd_dok_T3",   32'(f_if.data_ok), 32'd0);

    // Partial write then read-back of the same word
    f_if.req = 1'b1; f_if.wr = 1'b1; f_if.addr = 32'h80;
    f_if.wstrb = 4'b0011; f_if.wdata = 32'h1234_5678;
    #1;
    check("wr_ram_we",    32'(f_ram_we),   32'h3);
    check("wr_ram_wdata", f_ram_wdata,     32'h1234_5678);
    check("wr_ram_addr",  32'(f_ram_addr), 32'h20);
    tick();
    f_if.wr = 1'b0; f_if.wstrb = 4'b0000;
    #1;
    check("wr_rd_addr_ok", 32'(f_if.addr_ok), 32'd1);
    check("wr_rd_ram_we",  32'(f_ram_we),     32'h0);
    tick();
    f_if.req = 1'b0;
    #1;
    check("wr_dok_T2",   32'(f_if.data_ok), 32'd1);
    check("wr_rdata_T2", f_if.rdata,        32'h0);
    tick();
    check("wr_dok_T3",   32'(f_if.data_ok), 32'd1);
    check("wr_rdata_T3", f_if.rdata,        32'hFFFF_5678);
    tick();
    check("wr_dok_T4",   32'(f_if.data_ok), 32'd0);

    // Streaming 16 reads, words 0..15
    for (int k = 0; k < 19; k++) begin
      f_if.req  = (k < 16);
      f_if.wr   = 1'b0;
      f_if.addr = 32'(k * 4);
      #1;
      if (k < 16) check("st_addr_ok", 32'(f_if.addr_ok), 32'd1);
      if (k >= 2 && k < 18) begin
        check("st_data_ok", 32'(f_if.data_ok), 32'd1);
        check("st_rdata",   f_if.rdata,        exp_stream[k-2]);
      end else begin
        check("st_data_ok_idle", 32'(f_if.data_ok), 32'd0);
      end
      tick();
    end

    // Reset with two reads outstanding
    f_if.req = 1'b1; f_if.addr = 32'h0;
    #1;
    tick();
    f_if.addr = 32'h4;
    #1;
    resetn = 1'b0;
    #1;
    f_if.req = 1'b0;
    check("mr_dok_in_rst", 32'(f_if.data_ok), 32'd0);
    tick();
    resetn = 1'b1;
    #1;
    check("mr_addr_ok", 32'(f_if.addr_ok), 32'd1);
    check("mr_rdata",   f_if.rdata,        32'h0);
    for (int k = 0; k < 5; k++) begin
      check("mr_no_stale_dok", 32'(f_if.data_ok), 32'd0);
      tick();
    end

    // Full back-pressure on the LATENCY=8 instance
    n = 0;
    r = 0;
    for (int c = 0; c < 20; c++) begin
      s_if.req  = (n < 5);
      s_if.wr   = 1'b0;
      s_if.addr = 32'h100 + 32'(n * 4);
      #1;
      exp_aok = (c < 4) || (c >= 9);
      exp_dok = (c >= 8 && c <= 11) || (c == 17);
      check("full_addr_ok", 32'(s_if.addr_ok), 32'(exp_aok));
      check("full_ram_en",  32'(s_ram_en),     32'(s_if.req & exp_aok));
      check("full_data_ok", 32'(s_if.data_ok), 32'(exp_dok));
      if (exp_dok) begin
        check("full_rdata", s_if.rdata, 32'hC0DE_0000 + 32'(r));
        r++;
      end
      if (s_if.req && s_if.addr_ok) n++;
      tick();
    end
    check("full_accepts", 32'(n), 32'd5);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/sram_like_slave.md
Name: sram_like_slave

Overview:
Memory-side responder for the CPU's sram-like ports (req/addr_ok/data_ok). The SoC top instantiates it twice, once for the instruction port and once for the data port, between mycpu_top and a synchronous single-port block RAM. It accepts up to DEPTH outstanding requests and issues each to the RAM on acceptance. Responses (data_ok) return strictly in order, no earlier than LATENCY cycles after acceptance.

Parameters:
DEPTH, 4, max outstanding requests; power of 2, >=2
LATENCY, 2, cycles from address handshake to earliest data_ok; >=1
ADDR_W, 16, RAM word-address width; RAM word index = addr[ADDR_W+1:2]

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req  in  1  request valid from CPU
wr  in  1  1=write, 0=read
size  in  2  access size; informational only, wstrb is authoritative
wstrb  in  4  byte write enables (write only)
addr  in  32  byte address
wdata  in  32  write data
addr_ok  out  1  request accepted this cycle when req&addr_ok
data_ok  out  1  response valid; CPU always consumes it
rdata  out  32  read data, valid with data_ok
ram_en  out  1  RAM enable
ram_we  out  4  RAM byte write enables
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid one cycle after ram_en

Behaviour:
- Single clock is clk. resetn is asynchronous, active-low, and clears all state immediately.
- Reset values: count=0, pointers=0, all entry valid bits 0, data_ok=0, rdata=0, ram_en=0, ram_we=0. addr_ok=1 as soon as reset releases (count=0).
- addr_ok = (count < DEPTH), using the registered count. A pop in the same cycle does not free a slot for a push while full.
- Accept (acc = req & addr_ok):
  - Combinationally drive ram_en=1, ram_addr=addr[ADDR_W+1:2], ram_wdata=wdata, ram_we = wr ? wstrb : 4'b0.
  - Push an entry {is_wr, age=0, data_vld=0} at wptr.
- Cycle after an accepted read: write ram_rdata into the entry at the delayed wptr and set data_vld=1. Writes store 0 and set data_vld=1.
- Age: each valid entry increments age every cycle, saturating at LATENCY.
- Response: when the head entry is valid, age==LATENCY and data_vld:
  - data_ok=1 and rdata=head data, both registered outputs.
  - Pop head. data_ok lasts exactly one cycle per response.
- Timing: accept at T gives data_ok at T+LATENCY when the head is free. Back-to-back accepts at T, T+1 give data_ok at T+LATENCY, T+LATENCY+1. Sustained throughput is 1 per cycle while DEPTH > LATENCY.
- Push and pop in the same cycle: count unchanged; both pointers advance and wrap modulo DEPTH.
- Full: addr_ok=0 and ram_en=0 regardless of req. The CPU must hold req/addr/wr/wstrb/wdata stable until addr_ok.
- Ordering: responses for reads and writes are in acceptance order. A read issued the cycle after a write to the same word returns the new data, because the RAM is read-after-write coherent across cycles.
- Reset mid-operation: all outstanding requests are dropped and no data_ok follows. The CPU resets in the same domain, so this is consistent.

Decomposition:
- Package sram_like_pkg holds:
  - entry struct {is_wr, age, data_vld, data[31:0]}
  - RESP_RDATA_WR = 32'h0
  - localparam PTR_W = $clog2(DEPTH)
- Sub-module: resp_fifo (DEPTH entries, push/pop/data write-back port, count output). The top holds accept logic, RAM drive and response registers.

Test Plan:
- Reset release: assert resetn=0 mid-run with 2 requests outstanding -> addr_ok=1, data_ok=0, rdata=0 after release; no stale data_ok ever appears.
- Single read, LATENCY=2: RAM word 0x10 = 32'hDEADBEEF; req at T with addr=0x40 -> ram_en=1, ram_addr=0x10 at T; data_ok=1 with rdata=32'hDEADBEEF at T+2 only.
- Write then read: write addr=0x80, wstrb=4'b0011, wdata=32'h12345678 over old 32'hFFFFFFFF at T; read 0x80 at T+1 -> data_ok at T+2 (rdata=0) and T+3 (rdata=32'hFFFF5678).
- Full back-pressure, DEPTH=4, LATENCY=8: req held high -> exactly 4 accepts at T..T+3, addr_ok=0 from T+4; first data_ok at T+8; next accept at T+9; 5 responses in order.
- Streaming, DEPTH=4, LATENCY=2: 16 consecutive reads of words 0..15 -> addr_ok never drops; data_ok high 16 consecutive cycles from T+2; rdata sequence matches RAM words 0..15; pointers wrap correctly.
